// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated word memory responder for the core's memory stage
module dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        mem_stall,
  input  logic [31:0] dbg_addr,
  output logic [31:0] dbg_rdata
);
  localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic re_q, we_q, err_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] a_s, wd_s;
  logic re_s, we_s, req, bad, dbg_ok;
  logic [29:0] off, dbg_off;
  assign req = mem_re | mem_we;
  assign a_s = state == IDLE ? mem_addr : addr_q;
  assign wd_s = state == IDLE ? mem_wdata : wdata_q;
  assign re_s = state == IDLE ? mem_re : re_q;
  assign we_s = state == IDLE ? mem_we : we_q;
  assign off = a_s[31:2] - BASE_ADDR[31:2];
  assign bad = a_s[1:0] != 2'd0 || a_s[31:2] < BASE_ADDR[31:2] || off >= 30'(DEPTH_WORDS) || (re_s && we_s);
  assign dbg_off = dbg_addr[31:2] - BASE_ADDR[31:2];
  assign dbg_ok = dbg_addr[31:2] >= BASE_ADDR[31:2] && dbg_off < 30'(DEPTH_WORDS);
  assign dbg_rdata = dbg_ok ? mem[dbg_off[IW-1:0]] : 32'd0;
  assign mem_ready = state == RESP;
  assign mem_rdata = mem_ready ? rdata_q : 32'd0;
  assign mem_err = mem_ready & err_q;
  assign mem_stall = req & ~mem_ready;
  always_comb
    state_nxt = state == IDLE ? (req ? (WAIT_CYCLES > 0 ? WAIT : RESP) : IDLE) :
                state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      rdata_q <= 32'd0;
      err_q <= 1'b0;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      re_q <= 1'b0;
      we_q <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        addr_q <= mem_addr;
        wdata_q <= mem_wdata;
        re_q <= mem_re;
        we_q <= mem_we;
        cnt <= 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state_nxt == RESP) begin
        err_q <= bad;
        rdata_q <= (!bad && re_s) ? mem[off[IW-1:0]] : 32'd0;
        if (!bad && we_s) mem[off[IW-1:0]] <= wd_s;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
module tb_dmem_responder;
  logic clk;
  logic rst [3], re [3], we [3], ready [3], err [3], stall [3];
  logic [31:0] addr [3], wdata [3], rdata [3], dbga [3], dbgr [3];
  int tests = 0, fails = 0;
  dmem_responder #(.WAIT_CYCLES(2)) u0 (.clk(clk), .rst(rst[0]), .mem_re(re[0]), .mem_we(we[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ready(ready[0]),
    .mem_err(err[0]), .mem_stall(stall[0]), .dbg_addr(dbga[0]), .dbg_rdata(dbgr[0]));
  dmem_responder #(.WAIT_CYCLES(0)) u1 (.clk(clk), .rst(rst[1]), .mem_re(re[1]), .mem_we(we[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ready(ready[1]),
    .mem_err(err[1]), .mem_stall(stall[1]), .dbg_addr(dbga[1]), .dbg_rdata(dbgr[1]));
  dmem_responder #(.WAIT_CYCLES(1), .BASE_ADDR(32'h0000_1000)) u2 (.clk(clk), .rst(rst[2]), .mem_re(re[2]),
    .mem_we(we[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_rdata(rdata[2]), .mem_ready(ready[2]),
    .mem_err(err[2]), .mem_stall(stall[2]), .dbg_addr(dbga[2]), .dbg_rdata(dbgr[2]));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic xact(input int i, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic e, output int lat, output logic ok);
    re[i] = r; we[i] = w; addr[i] = a; wdata[i] = d; lat = 0; ok = 1;
    #1;
    if (ready[i]) begin @(negedge clk); #1; lat++; end
    while (!ready[i] && lat < 40) begin
      if (!stall[i]) ok = 0;
      @(negedge clk); #1; lat++;
    end
    rd = rdata[i]; e = err[i];
    if (stall[i]) ok = 0;
  endtask
  task automatic idle(input int i, input int n);
    re[i] = 0; we[i] = 0;
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic peek(input int i, input logic [31:0] a, output logic [31:0] v);
    dbga[i] = a; #1; v = dbgr[i];
  endtask
  task automatic test_reset;
    logic [31:0] v;
    for (int i = 0; i < 3; i++) begin
      tests++; if ({ready[i], err[i], stall[i]} !== 3'b000) begin fails++; $display("FAIL reset_flags[%0d]: got %b want 000", i, {ready[i], err[i], stall[i]}); end
      tests++; if (rdata[i] !== 32'd0) begin fails++; $display("FAIL reset_rdata[%0d]: got %h want 0", i, rdata[i]); end
      peek(i, i == 2 ? 32'h1000 : 32'h0, v);
      tests++; if (v !== 32'd0) begin fails++; $display("FAIL reset_dbg[%0d]: got %h want 0", i, v); end
    end
  endtask
  task automatic test_write_read;
    logic [31:0] rd, v; logic e, ok; int lat;
    @(negedge clk); #1;
    xact(0, 0, 1, 32'h10, 32'hDEADBEEF, rd, e, lat, ok);
    tests++; if (lat !== 3) begin fails++; $display("FAIL wr_latency: got %0d want 3", lat); end
    tests++; if ({e, ok} !== 2'b01) begin fails++; $display("FAIL wr_err_stall: got err=%b stall_ok=%b want 0 1", e, ok); end
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL wr_rdata: got %h want 0", rd); end
    peek(0, 32'h10, v);
    tests++; if (v !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_dbg4: got %h want deadbeef", v); end
    xact(0, 1, 0, 32'h10, 32'h0, rd, e, lat, ok);
    tests++; if (lat !== 4) begin fails++; $display("FAIL rd_latency: got %0d want 4", lat); end
    tests++; if ({rd, e} !== {32'hDEADBEEF, 1'b0}) begin fails++; $display("FAIL rd_data: got %h err=%b want deadbeef err=0", rd, e); end
    xact(0, 0, 1, 32'hFC, 32'h3F3F, rd, e, lat, ok);
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL top_word_err: got %b want 0", e); end
    peek(0, 32'hFC, v);
    tests++; if (v !== 32'h3F3F) begin fails++; $display("FAIL top_word_dbg: got %h want 3f3f", v); end
    idle(0, 2);
  endtask
  task automatic test_back_to_back;
    logic [31:0] rd, v; logic e, ok; int lat;
    @(negedge clk); #1;
    xact(1, 0, 1, 32'h0, 32'h11, rd, e, lat, ok);
    tests++; if (lat !== 1) begin fails++; $display("FAIL b2b_first_latency: got %0d want 1", lat); end
    xact(1, 0, 1, 32'h4, 32'h22, rd, e, lat, ok);
    tests++; if (lat !== 2) begin fails++; $display("FAIL b2b_wr2_latency: got %0d want 2", lat); end
    xact(1, 1, 0, 32'h0, 32'h0, rd, e, lat, ok);
    tests++; if ({lat, rd, e} !== {32'd2, 32'h11, 1'b0}) begin fails++; $display("FAIL b2b_rd0: got lat=%0d data=%h err=%b want 2 11 0", lat, rd, e); end
    xact(1, 1, 0, 32'h4, 32'h0, rd, e, lat, ok);
    tests++; if ({lat, rd, e} !== {32'd2, 32'h22, 1'b0}) begin fails++; $display("FAIL b2b_rd4: got lat=%0d data=%h err=%b want 2 22 0", lat, rd, e); end
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL b2b_stall: got %b want 1", ok); end
    idle(1, 1);
    tests++; if ({ready[1], stall[1]} !== 2'b00) begin fails++; $display("FAIL b2b_no_double: got %b want 00", {ready[1], stall[1]}); end
    peek(1, 32'h4, v);
    tests++; if (v !== 32'h22) begin fails++; $display("FAIL b2b_dbg1: got %h want 22", v); end
    idle(1, 1);
  endtask
  task automatic test_errors;
    logic [31:0] rd, v; logic e, ok; int lat;
    @(negedge clk); #1;
    xact(0, 0, 1, 32'h4, 32'hA1, rd, e, lat, ok);
    xact(0, 0, 1, 32'h8, 32'hA2, rd, e, lat, ok);
    xact(0, 0, 1, 32'h6, 32'hFFFF, rd, e, lat, ok);
    tests++; if ({lat, rd, e} !== {32'd4, 32'h0, 1'b1}) begin fails++; $display("FAIL misaligned: got lat=%0d data=%h err=%b want 4 0 1", lat, rd, e); end
    peek(0, 32'h4, v);
    tests++; if (v !== 32'hA1) begin fails++; $display("FAIL misaligned_w1: got %h want a1", v); end
    peek(0, 32'h8, v);
    tests++; if (v !== 32'hA2) begin fails++; $display("FAIL misaligned_w2: got %h want a2", v); end
    xact(0, 1, 0, 32'h100, 32'h0, rd, e, lat, ok);
    tests++; if ({lat, rd, e} !== {32'd4, 32'h0, 1'b1}) begin fails++; $display("FAIL out_of_range: got lat=%0d data=%h err=%b want 4 0 1", lat, rd, e); end
    xact(0, 1, 1, 32'h8, 32'h99, rd, e, lat, ok);
    tests++; if ({rd, e} !== {32'h0, 1'b1}) begin fails++; $display("FAIL re_we_both: got data=%h err=%b want 0 1", rd, e); end
    peek(0, 32'h8, v);
    tests++; if (v !== 32'hA2) begin fails++; $display("FAIL re_we_nowrite: got %h want a2", v); end
    peek(0, 32'h100, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL dbg_out_of_range: got %h want 0", v); end
    idle(0, 2);
  endtask
  task automatic test_reset_mid;
    logic [31:0] rd, v; logic e, ok; int lat; logic bad;
    @(negedge clk); #1;
    xact(0, 0, 1, 32'h20, 32'h77, rd, e, lat, ok);
    peek(0, 32'h20, v);
    tests++; if (v !== 32'h77) begin fails++; $display("FAIL pre_reset_dbg8: got %h want 77", v); end
    we[0] = 1; re[0] = 0; addr[0] = 32'h20; wdata[0] = 32'h55;
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst[0] = 1;
    @(negedge clk); #1;
    rst[0] = 0; we[0] = 0;
    bad = 0;
    repeat (6) begin
      #1; if (ready[0] || stall[0]) bad = 1;
      @(negedge clk); #1;
    end
    tests++; if (bad !== 1'b0) begin fails++; $display("FAIL reset_mid_quiet: got %b want 0", bad); end
    peek(0, 32'h20, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_mid_dbg8: got %h want 0", v); end
    peek(0, 32'h10, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_mid_dbg4: got %h want 0", v); end
  endtask
  task automatic test_base;
    logic [31:0] rd, v; logic e, ok; int lat;
    @(negedge clk); #1;
    xact(2, 0, 1, 32'h1004, 32'hCAFEF00D, rd, e, lat, ok);
    tests++; if ({lat, e} !== {32'd2, 1'b0}) begin fails++; $display("FAIL base_wr: got lat=%0d err=%b want 2 0", lat, e); end
    peek(2, 32'h1004, v);
    tests++; if (v !== 32'hCAFEF00D) begin fails++; $display("FAIL base_dbg1: got %h want cafef00d", v); end
    peek(2, 32'h1000, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL base_dbg0: got %h want 0", v); end
    xact(2, 1, 0, 32'h0FFC, 32'h0, rd, e, lat, ok);
    tests++; if ({lat, rd, e} !== {32'd3, 32'h0, 1'b1}) begin fails++; $display("FAIL below_base: got lat=%0d data=%h err=%b want 3 0 1", lat, rd, e); end
    xact(2, 1, 0, 32'h1004, 32'h0, rd, e, lat, ok);
    tests++; if ({rd, e} !== {32'hCAFEF00D, 1'b0}) begin fails++; $display("FAIL base_rd: got data=%h err=%b want cafef00d 0", rd, e); end
    idle(2, 2);
  endtask
  task automatic test_idle;
    @(negedge clk); #1;
    idle(0, 0);
    for (int c = 0; c < 10; c++) begin
      tests++; if (ready[0] !== 0 || err[0] !== 0 || stall[0] !== 0 || rdata[0] !== 0) begin
        fails++; $display("FAIL idle_cycle%0d: got ready=%b err=%b stall=%b data=%h want all 0", c, ready[0], err[0], stall[0], rdata[0]);
      end
      @(negedge clk); #1;
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1; re[i] = 0; we[i] = 0; addr[i] = 0; wdata[i] = 0; dbga[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 0;
    #1;
    test_reset;
    test_write_read;
    test_back_to_back;
    test_errors;
    test_reset_mid;
    test_base;
    test_idle;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
